// File: rtl/mem_stage.sv
// Memory pipeline stage: drives a req/ack data-memory access for loads and stores,
// stalls the EX/MEM latch while the access is in flight, and produces MEM/WB values.
module mem_stage #(
  parameter int unsigned DBITS               = 32,
  parameter int unsigned REG_INDEX_BIT_WIDTH = 4,
  parameter int unsigned TIMEOUT_CYCLES      = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [3:0]                     EX_func,
  input  logic [3:0]                     EX_op,
  input  logic [DBITS-1:0]               EX_regData2,
  input  logic [DBITS-1:0]               EX_intermediateResult,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] EX_rs2,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] EX_rd,
  input  logic                           EX_ME_mux_sel,
  input  logic                           EX_wrReg,
  input  logic                           EX_wrMem,
  input  logic                           wb_wrReg,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] wb_rd,
  input  logic [DBITS-1:0]               wb_data,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [DBITS-3:0]               mem_addr,
  output logic [DBITS-1:0]               mem_wdata,
  input  logic [DBITS-1:0]               mem_rdata,
  input  logic                           mem_ack,
  output logic                           stall,
  output logic [3:0]                     ME_op,
  output logic [REG_INDEX_BIT_WIDTH-1:0] ME_rd,
  output logic [DBITS-1:0]               ME_result,
  output logic                           ME_wrReg,
  output logic                           mem_misalign,
  output logic                           mem_timeout
);

  localparam int unsigned CBITS = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CBITS-1:0] LAST = CBITS'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state;
  logic [CBITS-1:0] count;
  logic             tflag;
  logic [DBITS-1:0] rdata_q;
  logic             memop;
  logic             misaligned;
  logic [DBITS-1:0] fwd;
  logic             unused_func;

  assign unused_func = ^EX_func;
  assign memop       = EX_wrMem | EX_ME_mux_sel;
  assign misaligned  = |EX_intermediateResult[1:0];
  assign fwd         = (wb_wrReg && (wb_rd == EX_rs2)) ? wb_data : EX_regData2;
  assign mem_req     = (state == ACCESS);

  // Gated by reset so every output reads 0 while reset is held.
  always_comb begin
    stall = 1'b0;
    if (reset) begin
      case (state)
        IDLE:    stall = memop & ~misaligned;
        ACCESS:  stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      tflag        <= 1'b0;
      rdata_q      <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ME_op        <= '0;
      ME_rd        <= '0;
      ME_result    <= '0;
      ME_wrReg     <= 1'b0;
      mem_misalign <= 1'b0;
      mem_timeout  <= 1'b0;
    end else begin
      mem_misalign <= 1'b0;
      mem_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          // Misaligned memory ops flow through like ALU ops but never write back.
          if (!memop || misaligned) begin
            ME_op        <= EX_op;
            ME_rd        <= EX_rd;
            ME_result    <= EX_intermediateResult;
            ME_wrReg     <= EX_wrReg & ~memop;
            mem_misalign <= memop;
          end else begin
            ME_wrReg  <= 1'b0;
            mem_addr  <= EX_intermediateResult[DBITS-1:2];
            mem_we    <= EX_wrMem;
            mem_wdata <= fwd;
            count     <= '0;
            tflag     <= 1'b0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          ME_wrReg <= 1'b0;
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            state   <= DONE;
          end else if (count == LAST) begin
            tflag <= 1'b1;
            state <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          ME_op       <= EX_op;
          ME_rd       <= EX_rd;
          ME_wrReg    <= EX_ME_mux_sel & ~EX_wrMem & ~tflag;
          ME_result   <= tflag ? '0 : rdata_q;
          mem_timeout <= tflag;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand sequences for reset and stray
// acks, and random ops checked against a transaction-level reference model.
module tb_mem_stage;
  localparam int unsigned DBITS = 32;
  localparam int unsigned RIBW  = 4;
  localparam int unsigned TO    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        EX_func, EX_op;
  logic [DBITS-1:0]  EX_regData2, EX_intermediateResult;
  logic [RIBW-1:0]   EX_rs2, EX_rd;
  logic              EX_ME_mux_sel, EX_wrReg, EX_wrMem;
  logic              wb_wrReg;
  logic [RIBW-1:0]   wb_rd;
  logic [DBITS-1:0]  wb_data;
  logic              mem_req, mem_we;
  logic [DBITS-3:0]  mem_addr;
  logic [DBITS-1:0]  mem_wdata, mem_rdata;
  logic              mem_ack, stall;
  logic [3:0]        ME_op;
  logic [RIBW-1:0]   ME_rd;
  logic [DBITS-1:0]  ME_result;
  logic              ME_wrReg, mem_misalign, mem_timeout;

  mem_stage #(.DBITS(DBITS), .REG_INDEX_BIT_WIDTH(RIBW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .EX_func(EX_func), .EX_op(EX_op), .EX_regData2(EX_regData2),
    .EX_intermediateResult(EX_intermediateResult), .EX_rs2(EX_rs2), .EX_rd(EX_rd),
    .EX_ME_mux_sel(EX_ME_mux_sel), .EX_wrReg(EX_wrReg), .EX_wrMem(EX_wrMem),
    .wb_wrReg(wb_wrReg), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .ME_op(ME_op), .ME_rd(ME_rd), .ME_result(ME_result), .ME_wrReg(ME_wrReg),
    .mem_misalign(mem_misalign), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd, rs2;
    logic [31:0] rd2, addr;
    logic        mux, wr_reg, wr_mem;
    logic        wb_wr;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    int unsigned ack_at;     // ACCESS cycle (1-based) carrying the ack; 0 = never
    logic [31:0] rdata;
    logic        e_wr;
    logic [31:0] e_res;
    logic        e_mis, e_to;
    int unsigned e_stall, e_req;
    logic [29:0] e_addr;
    logic        e_we;
    logic [31:0] e_wdata;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Memory responder state
  int unsigned ack_at   = 0;
  logic [31:0] ack_data = '0;
  bit          stray    = 1'b0;
  int unsigned req_cnt  = 0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (mem_req) begin
        req_cnt++;
        if (req_cnt == ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = ack_data;
        end
      end else begin
        req_cnt = 0;
        if (stray) begin
          mem_ack   = 1'b1;
          mem_rdata = 32'hBAD0_BAD0;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(string tag, string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, name, act, exp);
    end
  endtask

  function automatic vec_t v_in(logic [3:0] op, logic [3:0] rd, logic [3:0] rs2,
                                logic [31:0] rd2, logic [31:0] addr, logic mux,
                                logic wr_reg, logic wr_mem, logic wb_wr, logic [3:0] wbrd,
                                logic [31:0] wbd, int unsigned ack, logic [31:0] rdata);
    vec_t v;
    v.op = op; v.rd = rd; v.rs2 = rs2; v.rd2 = rd2; v.addr = addr;
    v.mux = mux; v.wr_reg = wr_reg; v.wr_mem = wr_mem;
    v.wb_wr = wb_wr; v.wb_rd = wbrd; v.wb_data = wbd;
    v.ack_at = ack; v.rdata = rdata;
    return v;
  endfunction

  function automatic vec_t v_exp(vec_t v, logic e_wr, logic [31:0] e_res, logic e_mis,
                                 logic e_to, int unsigned e_stall, int unsigned e_req,
                                 logic [29:0] e_addr, logic e_we, logic [31:0] e_wdata);
    v.e_wr = e_wr; v.e_res = e_res; v.e_mis = e_mis; v.e_to = e_to;
    v.e_stall = e_stall; v.e_req = e_req; v.e_addr = e_addr;
    v.e_we = e_we; v.e_wdata = e_wdata;
    return v;
  endfunction

  // Transaction-level reference: outcome of one op from the stage's rules.
  function automatic vec_t ref_model(vec_t v);
    bit memop;
    bit acked;
    memop     = v.wr_mem || v.mux;
    acked     = (v.ack_at >= 1) && (v.ack_at <= TO);
    v.e_mis   = 1'b0;
    v.e_to    = 1'b0;
    v.e_stall = 0;
    v.e_req   = 0;
    v.e_addr  = 30'(v.addr / 4);
    v.e_we    = v.wr_mem;
    v.e_wdata = (v.wb_wr && v.wb_rd == v.rs2) ? v.wb_data : v.rd2;
    if (!memop) begin
      v.e_wr  = v.wr_reg;
      v.e_res = v.addr;
    end else if (v.addr % 4 != 0) begin
      v.e_wr  = 1'b0;
      v.e_res = '0;
      v.e_mis = 1'b1;
    end else begin
      v.e_req   = acked ? v.ack_at : TO;
      v.e_stall = v.e_req + 1;
      v.e_to    = !acked;
      v.e_wr    = v.mux && !v.wr_mem && acked;
      v.e_res   = acked ? v.rdata : 32'h0;
    end
    return v;
  endfunction

  task automatic drive_nop();
    EX_func = '0; EX_op = '0; EX_regData2 = '0; EX_intermediateResult = '0;
    EX_rs2 = '0; EX_rd = '0; EX_ME_mux_sel = 1'b0; EX_wrReg = 1'b0; EX_wrMem = 1'b0;
    wb_wrReg = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic do_op(vec_t v, string tag);
    int unsigned stalls = 0;
    int unsigned reqs   = 0;
    int unsigned bad    = 0;
    bit          done   = 1'b0;
    @(posedge clk); #1;
    EX_func = 4'($urandom); EX_op = v.op; EX_regData2 = v.rd2;
    EX_intermediateResult = v.addr; EX_rs2 = v.rs2; EX_rd = v.rd;
    EX_ME_mux_sel = v.mux; EX_wrReg = v.wr_reg; EX_wrMem = v.wr_mem;
    wb_wrReg = v.wb_wr; wb_rd = v.wb_rd; wb_data = v.wb_data;
    ack_at = v.ack_at; ack_data = v.rdata;
    @(negedge clk);
    check(tag, "pulses_clear", {30'b0, mem_misalign, mem_timeout}, 32'h0);
    for (int c = 0; c < 200 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (mem_req) begin
        reqs++;
        if (mem_addr !== v.e_addr || mem_we !== v.e_we || mem_wdata !== v.e_wdata) bad++;
      end
      if (stall) stalls++;
      else done = 1'b1;
    end
    check(tag, "stall_released", {31'b0, done}, 32'h1);
    @(posedge clk); #1;
    drive_nop();
    @(negedge clk);
    check(tag, "ME_wrReg", {31'b0, ME_wrReg}, {31'b0, v.e_wr});
    check(tag, "misalign", {31'b0, mem_misalign}, {31'b0, v.e_mis});
    check(tag, "timeout", {31'b0, mem_timeout}, {31'b0, v.e_to});
    check(tag, "stall_cycles", stalls, v.e_stall);
    check(tag, "req_cycles", reqs, v.e_req);
    if (!v.e_mis) begin
      check(tag, "ME_result", ME_result, v.e_res);
      check(tag, "ME_rd", {28'b0, ME_rd}, {28'b0, v.rd});
      check(tag, "ME_op", {28'b0, ME_op}, {28'b0, v.op});
    end
    if (v.e_req > 0) check(tag, "mem_bus_bad_cycles", bad, 0);
  endtask

  task automatic check_all_zero(string tag);
    check(tag, "mem_req", {31'b0, mem_req}, 32'h0);
    check(tag, "mem_we", {31'b0, mem_we}, 32'h0);
    check(tag, "mem_addr", {2'b0, mem_addr}, 32'h0);
    check(tag, "mem_wdata", mem_wdata, 32'h0);
    check(tag, "stall", {31'b0, stall}, 32'h0);
    check(tag, "ME_op", {28'b0, ME_op}, 32'h0);
    check(tag, "ME_rd", {28'b0, ME_rd}, 32'h0);
    check(tag, "ME_result", ME_result, 32'h0);
    check(tag, "ME_wrReg", {31'b0, ME_wrReg}, 32'h0);
    check(tag, "pulses", {30'b0, mem_misalign, mem_timeout}, 32'h0);
  endtask

  vec_t tbl[11];
  vec_t rv;

  initial begin
    tbl[0]  = v_exp(v_in(4'd2, 4'd3, 4'd0, 32'h0, 32'h1234, 0, 1, 0, 0, 4'd0, 32'h0, 0, 32'h0),
                    1, 32'h1234, 0, 0, 0, 0, 30'h48D, 0, 32'h0);
    tbl[1]  = v_exp(v_in(4'd5, 4'd7, 4'd1, 32'h0, 32'h40, 1, 1, 0, 0, 4'd0, 32'h0, 3, 32'hCAFEF00D),
                    1, 32'hCAFEF00D, 0, 0, 4, 3, 30'h10, 0, 32'h0);
    tbl[2]  = v_exp(v_in(4'd6, 4'd0, 4'd5, 32'h1111, 32'h80, 0, 0, 1, 1, 4'd5, 32'hAA55, 1, 32'hBEEF),
                    0, 32'hBEEF, 0, 0, 2, 1, 30'h20, 1, 32'hAA55);
    tbl[3]  = v_exp(v_in(4'd5, 4'd4, 4'd0, 32'h0, 32'h42, 1, 1, 0, 0, 4'd0, 32'h0, 1, 32'h99),
                    0, 32'h0, 1, 0, 0, 0, 30'h10, 0, 32'h0);
    tbl[4]  = v_exp(v_in(4'd5, 4'd8, 4'd0, 32'h0, 32'h100, 1, 1, 0, 0, 4'd0, 32'h0, 0, 32'h77),
                    0, 32'h0, 0, 1, 17, 16, 30'h40, 0, 32'h0);
    tbl[5]  = v_exp(v_in(4'd3, 4'd9, 4'd0, 32'h0, 32'hDEADBEE0, 0, 1, 0, 0, 4'd0, 32'h0, 0, 32'h0),
                    1, 32'hDEADBEE0, 0, 0, 0, 0, 30'h37AB6FB8, 0, 32'h0);
    tbl[6]  = v_exp(v_in(4'd7, 4'd10, 4'd3, 32'h55, 32'h8, 1, 1, 1, 1, 4'd4, 32'hFFFF, 2, 32'h1357),
                    0, 32'h1357, 0, 0, 3, 2, 30'h2, 1, 32'h55);
    tbl[7]  = v_exp(v_in(4'd5, 4'd11, 4'd0, 32'h0, 32'hC, 1, 1, 0, 0, 4'd0, 32'h0, 16, 32'h12345678),
                    1, 32'h12345678, 0, 0, 17, 16, 30'h3, 0, 32'h0);
    tbl[8]  = v_exp(v_in(4'd6, 4'd0, 4'd2, 32'h77, 32'h10, 0, 0, 1, 0, 4'd2, 32'hFFFF, 1, 32'h0),
                    0, 32'h0, 0, 0, 2, 1, 30'h4, 1, 32'h77);
    tbl[9]  = v_exp(v_in(4'd1, 4'd12, 4'd0, 32'h0, 32'hABC, 0, 0, 0, 0, 4'd0, 32'h0, 0, 32'h0),
                    0, 32'hABC, 0, 0, 0, 0, 30'h2AF, 0, 32'h0);
    tbl[10] = v_exp(v_in(4'd6, 4'd0, 4'd1, 32'h5, 32'h81, 0, 0, 1, 0, 4'd0, 32'h0, 1, 32'h0),
                    0, 32'h0, 1, 0, 0, 0, 30'h20, 1, 32'h5);

    reset = 1'b0;
    drive_nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    for (int i = 0; i < 11; i++) do_op(tbl[i], $sformatf("vec%0d", i));

    // Stray acks while no access is in flight must be ignored.
    stray = 1'b1;
    do_op(ref_model(v_in(4'd2, 4'd6, 4'd0, 32'h0, 32'h5555, 0, 1, 0, 0, 4'd0, 32'h0, 0, 32'h0)), "stray_alu");
    do_op(ref_model(v_in(4'd5, 4'd13, 4'd0, 32'h0, 32'h20, 1, 1, 0, 0, 4'd0, 32'h0, 2, 32'h0F0F0F0F)), "stray_load");
    stray = 1'b0;

    // Reset asserted during the second ACCESS cycle.
    @(posedge clk); #1;
    EX_intermediateResult = 32'h200; EX_ME_mux_sel = 1'b1; EX_wrReg = 1'b1; EX_rd = 4'd14;
    wb_wrReg = 1'b1; wb_rd = '0; wb_data = 32'h1;
    EX_regData2 = 32'h3; ack_at = 0;
    repeat (3) @(negedge clk);
    check("midreset", "req_before", {31'b0, mem_req}, 32'h1);
    #1 reset = 1'b0;
    #1 check_all_zero("midreset");
    @(posedge clk); #1;
    drive_nop();
    @(negedge clk);
    check_all_zero("midreset_held");
    reset = 1'b1;
    do_op(ref_model(v_in(4'd5, 4'd15, 4'd0, 32'h0, 32'h300, 1, 1, 0, 0, 4'd0, 32'h0, 2, 32'h600DF00D)), "after_reset");

    for (int i = 0; i < 40; i++) begin
      rv.op     = 4'($urandom);
      rv.rd     = 4'($urandom);
      rv.rs2    = 4'($urandom);
      rv.rd2    = $urandom;
      rv.addr   = $urandom;
      rv.mux    = 1'($urandom);
      rv.wr_mem = ($urandom_range(0, 2) == 0);
      rv.wr_reg = 1'($urandom);
      if ($urandom_range(0, 3) != 0) rv.addr[1:0] = 2'b00;
      rv.wb_wr   = 1'($urandom);
      rv.wb_rd   = ($urandom_range(0, 1) == 0) ? rv.rs2 : 4'($urandom);
      rv.wb_data = $urandom;
      rv.ack_at  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
      rv.rdata   = $urandom;
      do_op(ref_model(rv), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
